// File: rtl/ps2_host_tx_pkg.sv
// Shared types and timing constants for the PS/2 host-to-device transmitter.
package ps2_host_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RELEASE,
        SHIFT,
        ACK,
        WAITHI,
        FINISH
    } ps2tx_state_t;

    localparam int PS2_INHIBIT_US = 100;
    localparam int PS2_TIMEOUT_US = 2000;

    // Divide by whole periods-per-second so 28 MHz gives exactly 2800 / 56000 cycles.
    function automatic int us_to_cycles(input int clk_freq, input int us);
        return clk_freq / (1_000_000 / us);
    endfunction

endpackage

// File: rtl/ps2_host_tx_filter.sv
// ps2_filter: 2-flop synchroniser, 4-sample majority filter with hysteresis, falling-edge strobe.
module ps2_filter (
    input  logic clk28,
    input  logic rst_n,
    input  logic line_in,
    output logic level,
    output logic fall
);

    logic [1:0] sync_q;
    logic [3:0] hist_q;
    logic [2:0] ones;

    function automatic logic [2:0] count4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    always_comb ones = count4(hist_q);

    // A 2/2 split holds the previous level, so a single glitch never toggles the output.
    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            hist_q <= 4'hF;
            level  <= 1'b1;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_in};
            hist_q <= {hist_q[2:0], sync_q[1]};
            fall   <= 1'b0;
            if (ones >= 3'd3) begin
                level <= 1'b1;
            end else if (ones <= 3'd1) begin
                level <= 1'b0;
                fall  <= level;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, start, 8 data, parity, stop, device ACK).
// Optional watchdog enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx
    import ps2_host_tx_pkg::*;
#(
    parameter int CLK_FREQ = 28_000_000
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    input  logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int INHIBIT_CYC = us_to_cycles(CLK_FREQ, PS2_INHIBIT_US);
    localparam int INH_W       = $clog2(INHIBIT_CYC);
    localparam int DAT_LEAD    = 4;

    ps2tx_state_t     state;
    logic [INH_W-1:0] inh_cnt;
    logic [3:0]       edge_cnt;
    logic [8:0]       shreg;
    logic             ack_err;
    logic             clk_level, clk_fall;
    logic             dat_level, dat_fall_unused;

`ifdef PS2_TX_TIMEOUT_EN
    localparam int TIMEOUT_CYC = us_to_cycles(CLK_FREQ, PS2_TIMEOUT_US);
    localparam int WD_W        = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expired;
    always_comb wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));
`endif

    ps2_filter u_clk_filt (
        .clk28   (clk28),
        .rst_n   (rst_n),
        .line_in (ps2_clk_in),
        .level   (clk_level),
        .fall    (clk_fall)
    );

    ps2_filter u_dat_filt (
        .clk28   (clk28),
        .rst_n   (rst_n),
        .line_in (ps2_dat_in),
        .level   (dat_level),
        .fall    (dat_fall_unused)
    );

    always_ff @(posedge clk28) begin
        if (!rst_n) begin
            state      <= IDLE;
            inh_cnt    <= '0;
            edge_cnt   <= '0;
            ack_err    <= 1'b0;
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
            wd_cnt <= wd_cnt + 1'b1;
`endif
            case (state)
                IDLE: begin
                    if (tx_req) begin
                        shreg      <= {~^tx_data, tx_data};
                        inh_cnt    <= '0;
                        ps2_clk_oe <= 1'b1;
                        busy       <= 1'b1;
                        state      <= INHIBIT;
                    end
                end
                // Data is pulled low just before the clock is released so the start bit is set up.
                INHIBIT: begin
                    inh_cnt <= inh_cnt + 1'b1;
                    if (inh_cnt == INH_W'(INHIBIT_CYC - DAT_LEAD - 1))
                        ps2_dat_oe <= 1'b1;
                    if (inh_cnt == INH_W'(INHIBIT_CYC - 1)) begin
                        ps2_clk_oe <= 1'b0;
                        edge_cnt   <= '0;
                        state      <= RELEASE;
`ifdef PS2_TX_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                    end
                end
                RELEASE: state <= SHIFT;
                // Edges 1..9 put out data LSB-first then parity; edge 10 releases data for stop.
                SHIFT: begin
                    if (clk_fall) begin
                        edge_cnt <= edge_cnt + 4'd1;
`ifdef PS2_TX_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                        if (edge_cnt == 4'd9) begin
                            ps2_dat_oe <= 1'b0;
                            state      <= ACK;
                        end else begin
                            ps2_dat_oe <= ~shreg[0];
                            shreg      <= {1'b0, shreg[8:1]};
                        end
                    end
                end
                ACK: begin
                    if (clk_fall) begin
                        edge_cnt <= 4'd11;
                        ack_err  <= dat_level;
                        state    <= WAITHI;
`ifdef PS2_TX_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                WAITHI: begin
                    if (clk_level && dat_level) begin
                        done  <= 1'b1;
                        err   <= ack_err;
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef PS2_TX_TIMEOUT_EN
            if (wd_expired && (state inside {RELEASE, SHIFT, ACK, WAITHI})) begin
                ps2_clk_oe <= 1'b0;
                ps2_dat_oe <= 1'b0;
                done       <= 1'b1;
                err        <= 1'b1;
                state      <= FINISH;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int INH_CYC   = 2800;
    localparam int TO_CYC    = 56000;
    localparam int FAST_HALF = 100;
`ifdef PS2_TX_TIMEOUT_EN
    localparam int ED_HALF   = FAST_HALF;
`else
    localparam int ED_HALF   = 1120;
`endif

    typedef enum int {DEV_ACK, DEV_NACK, DEV_SILENT} dev_mode_t;
    typedef struct packed {
        logic [7:0] data;
        logic       par;
        logic       err;
        logic       chk_frame;
        logic       chk_time;
    } exp_t;

    logic       clk28 = 1'b0;
    logic       rst_n = 1'b0;
    logic       tx_req = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, err;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       clk_line, dat_line;

    assign clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host_tx #(.CLK_FREQ(28_000_000)) dut (
        .clk28      (clk28),
        .rst_n      (rst_n),
        .ps2_clk_in (clk_line),
        .ps2_dat_in (dat_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk28 = ~clk28;

    int        cyc = 0;
    int        tests = 0;
    int        failed = 0;
    int        done_cnt = 0;
    int        rel_cyc = 0;
    exp_t      exp_q[$];
    event      host_req;
    dev_mode_t dev_mode = DEV_ACK;
    int        dev_half = FAST_HALF;
    int        dev_edge = 0;
    logic      dev_busy = 1'b0;
    logic [7:0] dev_byte = 8'h00;
    logic      dev_par = 1'b0, dev_stop = 1'b0, dev_start = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial forever begin
        @(posedge clk28);
        cyc++;
    end

    // Inhibit timing monitor; fires host_req at each clock release.
    initial begin
        int   inh_len = 0;
        int   lead = 0;
        logic prev_clk_oe = 1'b0;
        forever begin
            @(negedge clk28);
            if (ps2_clk_oe) begin
                inh_len++;
                if (ps2_dat_oe) lead++;
            end else if (prev_clk_oe) begin
                chk("inhibit_len", inh_len, INH_CYC);
                chk("dat_lead_cycles", lead, 4);
                chk("start_bit_oe", ps2_dat_oe, 1'b1);
                rel_cyc = cyc;
                inh_len = 0;
                lead    = 0;
                -> host_req;
            end
            prev_clk_oe = ps2_clk_oe;
        end
    end

    // Device: clocks 11 pulses, samples data while clock is low, optional ACK on pulse 11.
    initial forever begin
        @(host_req);
        if (dev_mode != DEV_SILENT) begin
            dev_busy = 1'b1;
            dev_edge = 0;
            repeat (50) @(posedge clk28);
            dev_start = dat_line;
            for (int k = 1; k <= 11; k++) begin
                if (k == 11 && dev_mode == DEV_ACK) dev_dat_low = 1'b1;
                repeat (dev_half) @(posedge clk28);
                dev_clk_low = 1'b1;
                dev_edge    = k;
                repeat (dev_half) @(posedge clk28);
                if (k <= 8)       dev_byte[k-1] = dat_line;
                else if (k == 9)  dev_par  = dat_line;
                else if (k == 10) dev_stop = dat_line;
                dev_clk_low = 1'b0;
            end
            repeat (dev_half) @(posedge clk28);
            dev_dat_low = 1'b0;
            dev_busy    = 1'b0;
        end
    end

    // Scoreboard monitor: pops one expectation per done pulse.
    initial begin
        exp_t e;
        logic pend = 1'b0;
        forever begin
            @(negedge clk28);
            if (pend) begin
                chk("busy_drop_after_done", busy, 1'b0);
                chk("done_one_cycle", done, 1'b0);
                pend = 1'b0;
            end
            if (done) begin
                done_cnt++;
                pend = 1'b1;
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL unexpected_done: got done=1, required no done");
                end else begin
                    e = exp_q.pop_front();
                    chk("err", err, e.err);
                    if (e.chk_frame) begin
                        chk("frame_start", dev_start, 1'b0);
                        chk("frame_data", dev_byte, e.data);
                        chk("frame_parity", dev_par, e.par);
                        chk("frame_stop", dev_stop, 1'b1);
                    end
                    if (e.chk_time) chk("timeout_cycles", cyc - rel_cyc, TO_CYC);
                end
            end
        end
    end

    task automatic pulse_req(input logic [7:0] b);
        @(posedge clk28);
        #1 tx_req = 1'b1;
        tx_data = b;
        @(posedge clk28);
        #1 tx_req = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input exp_t e);
        exp_q.push_back(e);
        pulse_req(b);
        chk("busy_after_req", busy, 1'b1);
    endtask

    task automatic wait_done(input int target, input int bound);
        int t = 0;
        while (done_cnt < target && t < bound) begin
            @(posedge clk28);
            t++;
        end
        chk("done_arrived", done_cnt, target);
        repeat (3) @(posedge clk28);
    endtask

    task automatic wait_dev_idle(input int bound);
        int t = 0;
        while (dev_busy && t < bound) begin
            @(posedge clk28);
            t++;
        end
        chk("device_idle", dev_busy, 1'b0);
        repeat (20) @(posedge clk28);
    endtask

    task automatic wait_edge(input int k, input int bound);
        int t = 0;
        while (dev_edge != k && t < bound) begin
            @(posedge clk28);
            t++;
        end
        chk("device_edge_reached", dev_edge, k);
    endtask

    initial begin
        repeat (3) @(posedge clk28);
        #1;
        chk("reset_clk_oe", ps2_clk_oe, 1'b0);
        chk("reset_dat_oe", ps2_dat_oe, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_err", err, 1'b0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk28);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, ACK
        dev_mode = DEV_ACK;
        dev_half = ED_HALF;
        send(8'hED, '{8'hED, 1'b1, 1'b0, 1'b1, 1'b0});
        wait_done(1, INH_CYC + 30 * 2 * ED_HALF);
        wait_dev_idle(4 * ED_HALF);

        // 0xF4: five ones -> parity 0
        dev_half = FAST_HALF;
        send(8'hF4, '{8'hF4, 1'b0, 1'b0, 1'b1, 1'b0});
        wait_done(2, INH_CYC + 30 * 2 * FAST_HALF);
        wait_dev_idle(4 * FAST_HALF);

        // No ACK: data left high on pulse 11
        dev_mode = DEV_NACK;
        send(8'hA5, '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0});
        wait_done(3, INH_CYC + 30 * 2 * FAST_HALF);
        wait_dev_idle(4 * FAST_HALF);

        // Reset after edge 5 while bit 4 (=0) is being driven low
        dev_mode = DEV_ACK;
        pulse_req(8'h0C);
        wait_edge(5, INH_CYC + 20 * FAST_HALF);
        repeat (20) @(posedge clk28);
        chk("bit4_driven_low", ps2_dat_oe, 1'b1);
        #1 rst_n = 1'b0;
        @(posedge clk28);
        #1;
        chk("midreset_clk_oe", ps2_clk_oe, 1'b0);
        chk("midreset_dat_oe", ps2_dat_oe, 1'b0);
        chk("midreset_busy", busy, 1'b0);
        rst_n = 1'b1;
        wait_dev_idle(30 * FAST_HALF);
        chk("no_done_after_reset", done_cnt, 3);

        // 0xFF with a stray request during SHIFT
        send(8'hFF, '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0});
        wait_edge(3, INH_CYC + 20 * FAST_HALF);
        pulse_req(8'h00);
        chk("busy_during_stray_req", busy, 1'b1);
        wait_done(4, 30 * 2 * FAST_HALF);
        wait_dev_idle(4 * FAST_HALF);
        repeat (INH_CYC + 200) @(posedge clk28);
        chk("stray_req_ignored_busy", busy, 1'b0);
        chk("one_done_per_accept", done_cnt, 4);

        // Silent device
        dev_mode = DEV_SILENT;
`ifdef PS2_TX_TIMEOUT_EN
        send(8'h55, '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1});
        wait_done(5, INH_CYC + TO_CYC + 1000);
        chk("timeout_lines_released", {ps2_clk_oe, ps2_dat_oe}, 2'b00);
        chk("done_total", done_cnt, 5);
`else
        pulse_req(8'h55);
        repeat (INH_CYC + 6000) @(posedge clk28);
        #1;
        chk("busy_hold_silent", busy, 1'b1);
        chk("start_bit_held_silent", ps2_dat_oe, 1'b1);
        chk("done_total", done_cnt, 4);
        rst_n = 1'b0;
        @(posedge clk28);
        #1 rst_n = 1'b1;
        chk("busy_cleared_by_reset", busy, 1'b0);
`endif
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_FREQ, default 28_000_000, system clock in Hz; all timing constants derive from it.
REQ-002 clk28  input  1  system clock; all logic on posedge.
REQ-003 rst_n  input  1  reset; synchronous, active-low; clock clk28.
REQ-004 ps2_clk_in  input  1  raw PS/2 clock line level, asynchronous.
REQ-005 ps2_dat_in  input  1  raw PS/2 data line level, asynchronous.
REQ-006 ps2_clk_oe  output  1  1 = pull PS/2 clock low (open-drain); 0 = release.
REQ-007 ps2_dat_oe  output  1  1 = pull PS/2 data low (open-drain); 0 = release.
REQ-008 tx_req  input  1  one-cycle strobe; start sending tx_data.
REQ-009 tx_data  input  8  command byte, captured on the accepted tx_req.
REQ-010 busy  output  1  transfer in progress; the ps2 receiver ignores the line while busy=1.
REQ-011 done  output  1  one-cycle pulse at transfer end.
REQ-012 err  output  1  valid with done; 1 = no device ACK, or timeout.

Function
REQ-013 Synchronise each input through 2 flops, then a 4-sample majority filter; detect ps2_clk falling edge as filtered 1->0.
REQ-014 FSM states: IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAITHI, FINISH.
REQ-015 IDLE: both oe=0, busy=0; tx_req latches tx_data and computes parity = ~^tx_data; go to INHIBIT next cycle; busy=1 from that cycle.
REQ-016 tx_req while busy=1 is ignored; no queueing.
REQ-017 INHIBIT: clk_oe=1 for CLK_FREQ/10000 cycles (100 us; 2800 at default); dat_oe=1 asserted for the last 4 cycles of the count.
REQ-018 RELEASE: clk_oe=0, dat_oe=1 (start bit); falling-edge counter n=0; go to SHIFT.
REQ-019 SHIFT: on falling edge n: n=1..8 drive data bit n-1 (LSB first, dat_oe=~bit); n=9 drive parity; n=10 dat_oe=0 (stop); go to ACK.
REQ-020 ACK: on falling edge 11 sample filtered data: 0 = ack ok, 1 = err; go to WAITHI.
REQ-021 WAITHI: wait until filtered clk=1 and data=1, then FINISH.
REQ-022 FINISH: done=1 for one cycle, err per REQ-020; busy=0 from the next cycle; return to IDLE.
REQ-023 Falling edges seen in INHIBIT/RELEASE are ignored; the edge counter is 4 bits and never wraps past 11.
REQ-024 Data-line changes occur only on the cycle after the detected falling edge; never while filtered clk=0 mid-bit.

Reset
REQ-025 rst_n=0 in any state: next cycle state=IDLE, clk_oe=0, dat_oe=0, busy=0, done=0, err=0, counters=0; mid-transfer bytes are dropped with no done.
REQ-026 Filter/synchroniser flops reset to 1 (idle-high line).

Configuration
REQ-027 Macro PS2_TX_TIMEOUT_EN.
- Defined: watchdog counts CLK_FREQ/500 cycles (2 ms; 56000 at default) from RELEASE entry and restarts at each falling edge.
- Expiry in RELEASE/SHIFT/ACK/WAITHI releases both lines and goes to FINISH with err=1.
- Not defined: no watchdog; a silent device holds busy=1 until reset.

Structure
REQ-028 Shared package holds the ps2tx_state_t enum and PS2_INHIBIT_US=100 / PS2_TIMEOUT_US=2000 constants.
REQ-029 One sub-module, ps2_filter (sync plus majority filter plus fall strobe), instantiated twice; the existing receiver reuses it.

Verification
REQ-030 tx_data=0xED, device model clocks at 12.5 kHz and acks -> data bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done with err=0.
REQ-031 tx_data=0xF4 -> parity bit 0; clk_oe high exactly 2800 cycles; dat_oe asserted before clk_oe drops.
REQ-032 Device leaves data high on the 11th edge -> done=1, err=1, busy drops the next cycle.
REQ-033 With PS2_TX_TIMEOUT_EN defined, device never clocks -> done/err=1 exactly 56000 cycles after RELEASE; without the macro -> busy stays 1.
REQ-034 rst_n=0 after edge 5 -> oe both 0 the next cycle, no done; a fresh tx_req=0xFF then completes with parity 1.
REQ-035 tx_req pulsed during SHIFT -> ignored; exactly one done per accepted request.
